// File: rtl/data_stack_pkg.sv
// Processor-wide shared definitions: data-stack operation encodings,
// also decoded by the control unit.
package data_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_PUSH     = 2'b01,
    OP_POP      = 2'b10,
    OP_POP2PUSH = 2'b11
  } stack_op_e;

endpackage

// File: rtl/data_stack.sv
// Operand data stack: tos/nos feed the operand-select mux directly.
// Illegal ops (overflow/underflow) are blocked and raise a sticky err.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         tos,
  output logic [WIDTH-1:0]         nos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] cnt_nxt;
  logic          bad_op;

  // Op decode: legal ops update pointer/write port, illegal ones only flag
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    cnt_nxt = count;
    bad_op  = 1'b0;
    case (stack_op_e'(op))
      OP_PUSH: begin
        if (full) begin
          bad_op = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count);
          cnt_nxt = count + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          bad_op = 1'b1;
        end else begin
          cnt_nxt = count - CW'(1);
        end
      end
      OP_POP2PUSH: begin
        if (count < CW'(2)) begin
          bad_op = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count - CW'(2));
          cnt_nxt = count - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Storage is never cleared; an op presented with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      empty <= (cnt_nxt == CW'(0));
      full  <= (cnt_nxt == CW'(DEPTH));
      if (bad_op) begin
        err <= 1'b1;
      end
    end
  end

  // Entries at or above count are masked so stale data never escapes
  always_comb begin
    tos = '0;
    nos = '0;
    if (count >= CW'(1)) begin
      tos = mem[AW'(count - CW'(1))];
    end
    if (count >= CW'(2)) begin
      nos = mem[AW'(count - CW'(2))];
    end
  end

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: queue-based reference stack, directed
// scenarios followed by phase-biased random ops with occasional reset.
module tb_data_stack;
  import data_stack_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       op    = 2'b00;
  logic [WIDTH-1:0] din   = '0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, err;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .din   (din),
    .tos   (tos),
    .nos   (nos),
    .count (count),
    .empty (empty),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;
    int               id;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model[$];
  logic             model_err = 1'b0;
  int               n_issued  = 0;
  int               checks    = 0;
  int               fails     = 0;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s (op #%0d): got %h, expected %h", name, id, act, expv);
    end
  endtask

  // Apply one op for one cycle and queue the state the stack must show after it
  task automatic issue(input logic r, input logic [1:0] o, input logic [WIDTH-1:0] d);
    exp_t e;
    int   n;
    @(negedge clk);
    reset = r;
    op    = o;
    din   = d;
    if (r) begin
      model.delete();
      model_err = 1'b0;
    end else begin
      case (o)
        OP_PUSH:
          if (model.size() >= DEPTH) model_err = 1'b1;
          else model.push_back(d);
        OP_POP:
          if (model.size() == 0) model_err = 1'b1;
          else void'(model.pop_back());
        OP_POP2PUSH:
          if (model.size() < 2) model_err = 1'b1;
          else begin
            void'(model.pop_back());
            void'(model.pop_back());
            model.push_back(d);
          end
        default: ;
      endcase
    end
    n       = model.size();
    e.count = CW'(n);
    e.tos   = (n >= 1) ? model[n-1] : '0;
    e.nos   = (n >= 2) ? model[n-2] : '0;
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.err   = model_err;
    e.id    = n_issued;
    n_issued++;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation is due just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tos",   e.id, 32'(tos),   32'(e.tos));
        check("nos",   e.id, 32'(nos),   32'(e.nos));
        check("count", e.id, 32'(count), 32'(e.count));
        check("empty", e.id, 32'(empty), 32'(e.empty));
        check("full",  e.id, 32'(full),  32'(e.full));
        check("err",   e.id, 32'(err),   32'(e.err));
      end
    end
  end

  initial begin
    int k;
    logic r;
    logic [1:0] o;

    // reset state, then two pushes and a combining pop2push
    issue(1'b1, OP_NOP, '0);
    issue(1'b0, OP_NOP, '0);
    issue(1'b0, OP_PUSH, 16'h0001);
    issue(1'b0, OP_PUSH, 16'h0002);
    issue(1'b0, OP_POP2PUSH, 16'h0003);
    issue(1'b0, OP_POP2PUSH, 16'h0004);   // count 1: underflow
    issue(1'b0, OP_NOP, '0);

    // fill to full, overflow, then legal pop2push at full
    issue(1'b1, OP_NOP, '0);
    for (int v = 0; v < 16; v++) issue(1'b0, OP_PUSH, WIDTH'(v));
    issue(1'b0, OP_PUSH, 16'hBEEF);
    issue(1'b0, OP_POP2PUSH, 16'h0100);
    issue(1'b0, OP_PUSH, 16'h0200);
    issue(1'b0, OP_PUSH, 16'h0300);

    // underflow on empty; sticky err with later legal ops
    issue(1'b1, OP_NOP, '0);
    issue(1'b0, OP_POP, '0);
    issue(1'b0, OP_PUSH, 16'h00AA);
    issue(1'b0, OP_POP2PUSH, 16'h00BB);
    issue(1'b0, OP_POP, '0);

    // reset mid-sequence wins over a simultaneous push
    issue(1'b1, OP_NOP, '0);
    for (int v = 0; v < 5; v++) issue(1'b0, OP_PUSH, WIDTH'(16'h0A00 + v));
    issue(1'b1, OP_PUSH, 16'h5555);
    issue(1'b0, OP_NOP, '0);

    // random ops alternating between fill-biased and drain-biased phases
    for (int i = 0; i < 800; i++) begin
      k = int'($urandom_range(0, 9));
      r = ($urandom_range(0, 149) == 0);
      if (((i / 60) % 2) == 0) begin
        o = (k < 5) ? OP_PUSH : (k < 7) ? OP_POP2PUSH : (k < 9) ? OP_POP : OP_NOP;
      end else begin
        o = (k < 2) ? OP_PUSH : (k < 5) ? OP_POP2PUSH : (k < 9) ? OP_POP : OP_NOP;
      end
      issue(r, o, WIDTH'($urandom));
    end
    issue(1'b0, OP_NOP, '0);

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", n_issued, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
